// File: rtl/sr_exwb_stage.sv
// Execute-to-writeback stage: selects Zbb/ALU result and queues it in a
// 2-entry skid buffer ahead of the register-file write port.
module sr_exwb_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic               ex_is_zbb,
    input  logic               ex_reg_write,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]    ex_alu_result,
    input  logic [XLEN-1:0]    ex_zbb_result,
    input  logic               wb_ready,
    output logic               wb_valid,
    output logic               wb_we,
    output logic [RADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]    wb_data,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]    fwd_data,
    input  logic [RADDR_W-1:0] hz_rs1,
    input  logic [RADDR_W-1:0] hz_rs2,
    output logic               hz_stall,
    output logic [31:0]        retire_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

    occ_t               state;
    logic               head_we,   skid_we;
    logic [RADDR_W-1:0] head_rd,   skid_rd;
    logic [XLEN-1:0]    head_data, skid_data;

    logic               head_valid, skid_valid;
    logic               accept, drain;
    logic               new_we;
    logic [RADDR_W-1:0] new_rd;
    logic [XLEN-1:0]    new_data;

    assign head_valid = (state != EMPTY);
    assign skid_valid = (state == FULL);
    assign accept     = ex_valid & ex_ready;
    assign drain      = head_valid & wb_ready;

    // x0 writes still occupy a slot but never strobe the register file
    assign new_we   = ex_reg_write & (ex_rd != '0);
    assign new_rd   = ex_rd;
    assign new_data = ex_is_zbb ? ex_zbb_result : ex_alu_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            ex_ready  <= 1'b1;
            head_we   <= 1'b0;
            head_rd   <= '0;
            head_data <= '0;
            skid_we   <= 1'b0;
            skid_rd   <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state    <= EMPTY;
            ex_ready <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head_we   <= new_we;
                        head_rd   <= new_rd;
                        head_data <= new_data;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        head_we   <= new_we;
                        head_rd   <= new_rd;
                        head_data <= new_data;
                    end else if (accept) begin
                        skid_we   <= new_we;
                        skid_rd   <= new_rd;
                        skid_data <= new_data;
                        state     <= FULL;
                        ex_ready  <= 1'b0;
                    end else if (drain) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        head_we   <= skid_we;
                        head_rd   <= skid_rd;
                        head_data <= skid_data;
                        skid_we   <= 1'b0;
                        state     <= ONE;
                        ex_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    ex_ready <= 1'b1;
                end
            endcase
        end
    end

    assign wb_valid  = head_valid;
    assign wb_we     = head_valid & head_we & wb_ready;
    assign wb_rd     = head_rd;
    assign wb_data   = head_data;

    assign fwd_valid = head_valid & head_we;
    assign fwd_rd    = head_rd;
    assign fwd_data  = head_data;

    assign hz_stall  = skid_valid & skid_we & ((skid_rd == hz_rs1) | (skid_rd == hz_rs2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_cnt <= '0;
        else if (wb_we)
            retire_cnt <= retire_cnt + 32'd1;
    end

endmodule

// File: tb/tb_sr_exwb_stage.sv
// Directed bench for sr_exwb_stage: inputs driven and outputs sampled on negedge.
module tb_sr_exwb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_zbb;
    logic        ex_reg_write;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_zbb_result;
    logic        wb_ready;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [4:0]  hz_rs1;
    logic [4:0]  hz_rs2;
    logic        hz_stall;
    logic [31:0] retire_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sr_exwb_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_zbb(ex_is_zbb),
        .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .ex_alu_result(ex_alu_result), .ex_zbb_result(ex_zbb_result),
        .wb_ready(wb_ready), .wb_valid(wb_valid), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_stall(hz_stall),
        .retire_cnt(retire_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic zbb, input logic rw, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] zres);
        ex_valid      = v;
        ex_is_zbb     = zbb;
        ex_reg_write  = rw;
        ex_rd         = rd;
        ex_alu_result = alu;
        ex_zbb_result = zres;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wb_ready = 1'b0; hz_rs1 = '0; hz_rs2 = '0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);

        // Reset values
        #12;
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_hz_stall", 32'(hz_stall), 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // 1: basic ALU write, 1-cycle latency
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 5'd5, 32'h11, 32'h0);
        wb_ready = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("t1_wb_valid", 32'(wb_valid), 32'd1);
        chk("t1_wb_we", 32'(wb_we), 32'd1);
        chk("t1_wb_rd", 32'(wb_rd), 32'd5);
        chk("t1_wb_data", wb_data, 32'h11);
        @(negedge clk);
        chk("t1_retire", retire_cnt, 32'd1);
        chk("t1_empty", 32'(wb_valid), 32'd0);

        // 2: Zbb select, then x0 destination
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'hDEAD, 32'h20);
        @(negedge clk);
        chk("t2_zbb_data", wb_data, 32'h20);
        chk("t2_zbb_we", 32'(wb_we), 32'd1);
        ex_rd = 5'd0;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("t2_x0_valid", 32'(wb_valid), 32'd1);
        chk("t2_x0_we", 32'(wb_we), 32'd0);
        chk("t2_x0_fwd", 32'(fwd_valid), 32'd0);
        chk("t2_retire_a", retire_cnt, 32'd2);
        @(negedge clk);
        chk("t2_retire_b", retire_cnt, 32'd2);
        chk("t2_empty", 32'(wb_valid), 32'd0);

        // 3: backpressure, A/B/C ordering and hazard detection
        wb_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 5'd1, 32'hA1, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 5'd2, 32'hB2, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 5'd7, 32'hC7, 32'h0);
        chk("t3_full_ready", 32'(ex_ready), 32'd0);
        chk("t3_head_rd", 32'(wb_rd), 32'd1);
        chk("t3_head_data", wb_data, 32'hA1);
        chk("t3_we_blocked", 32'(wb_we), 32'd0);
        chk("t3_fwd_valid", 32'(fwd_valid), 32'd1);
        chk("t3_fwd_data", fwd_data, 32'hA1);
        chk("t3_fwd_rd", 32'(fwd_rd), 32'd1);
        hz_rs1 = 5'd2; #1;
        chk("t3_hz_rs1", 32'(hz_stall), 32'd1);
        hz_rs1 = 5'd9; hz_rs2 = 5'd2; #1;
        chk("t3_hz_rs2", 32'(hz_stall), 32'd1);
        hz_rs2 = 5'd1; #1;
        chk("t3_hz_head_only", 32'(hz_stall), 32'd0);
        hz_rs1 = '0; hz_rs2 = '0;
        @(negedge clk);
        chk("t3_hold_data", wb_data, 32'hA1);
        chk("t3_hold_ready", 32'(ex_ready), 32'd0);
        wb_ready = 1'b1; #1;
        chk("t3_we_raised", 32'(wb_we), 32'd1);
        @(negedge clk);
        chk("t3_b_rd", 32'(wb_rd), 32'd2);
        chk("t3_b_data", wb_data, 32'hB2);
        chk("t3_ready_back", 32'(ex_ready), 32'd1);
        chk("t3_retire_a", retire_cnt, 32'd3);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("t3_c_rd", 32'(wb_rd), 32'd7);
        chk("t3_c_data", wb_data, 32'hC7);
        chk("t3_retire_b", retire_cnt, 32'd4);
        @(negedge clk);
        chk("t3_retire_c", retire_cnt, 32'd5);
        chk("t3_empty", 32'(wb_valid), 32'd0);

        // 4: flush in FULL with a simultaneous input
        wb_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 5'd4, 32'h44, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 5'd5, 32'h55, 32'h0);
        @(negedge clk);
        chk("t4_full", 32'(ex_ready), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 5'd6, 32'h66, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; ex_valid = 1'b0;
        chk("t4_wb_valid", 32'(wb_valid), 32'd0);
        chk("t4_ex_ready", 32'(ex_ready), 32'd1);
        chk("t4_retire", retire_cnt, 32'd5);
        wb_ready = 1'b1;
        @(negedge clk);
        chk("t4_lost", 32'(wb_valid), 32'd0);
        chk("t4_retire_b", retire_cnt, 32'd5);

        // Flush coinciding with a drain still writes
        drive(1'b1, 1'b0, 1'b1, 5'd8, 32'h88, 32'h0);
        @(negedge clk);
        ex_valid = 1'b0; flush = 1'b1; #1;
        chk("t4_flush_drain_we", 32'(wb_we), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        chk("t4_flush_drain_cnt", retire_cnt, 32'd6);
        chk("t4_flush_drain_empty", 32'(wb_valid), 32'd0);

        // 5: counter wrap
        wb_ready = 1'b0;
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1 release dut.retire_cnt;
        #1;
        chk("t5_preload", retire_cnt, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 1'b1, 5'd9, 32'h99, 32'h0);
        wb_ready = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("t5_we", 32'(wb_we), 32'd1);
        @(negedge clk);
        chk("t5_wrap", retire_cnt, 32'd0);

        // 6: asynchronous reset while FULL
        wb_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 5'd10, 32'hAA, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 5'd11, 32'hBB, 32'h0);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("t6_full", 32'(ex_ready), 32'd0);
        chk("t6_cnt_pre", retire_cnt, 32'd0);
        wb_ready = 1'b1; #1;
        chk("t6_we_pre", 32'(wb_we), 32'd1);
        rst_n = 1'b0; #1;
        chk("t6_valid_now", 32'(wb_valid), 32'd0);
        chk("t6_we_now", 32'(wb_we), 32'd0);
        chk("t6_ready_now", 32'(ex_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready_after", 32'(ex_ready), 32'd1);
        chk("t6_retire_after", retire_cnt, 32'd0);
        chk("t6_valid_after", 32'(wb_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
